// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, ALU op codes, decoded-instruction payload
// and the skid-buffer state encoding.
package proc_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned ALU_W   = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SLL  = 5'd1,
      ALU_SLT  = 5'd2,
      ALU_SLTU = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SRL  = 5'd5,
      ALU_OR   = 5'd6,
      ALU_AND  = 5'd7,
      ALU_SUB  = 5'd8,
      ALU_SRA  = 5'd9,
      ALU_NOP  = 5'd31
   } alu_op_e;

   // Decoded fields; the XLEN-wide immediate and pc travel alongside this struct.
   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      alu_op_e          alu_control;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             illegal;
   } dec_instr_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // Base func3 -> ALU op map shared by OP and OP-IMM.
   function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'd0:    op = ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = ALU_SRL;
         3'd6:    op = ALU_OR;
         3'd7:    op = ALU_AND;
         default: op = ALU_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I/RV64I base-integer decoder: raw instruction -> decoded fields
// plus sign-extended immediate. Illegal encodings collapse to an all-zero NOP payload.
module decode_core
   import proc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [INSTR_W-1:0] i_instr,
   output dec_instr_t         o_dec_c,
   output logic [XLEN-1:0]    o_imm_c
);

   localparam logic [6:0] SRA_HI = (XLEN == 64) ? 7'h10 : 7'h20;

   logic [6:0]       w_opcode;
   logic [2:0]       w_func3;
   logic [6:0]       w_func7;
   logic [6:0]       w_shift_hi;
   logic [XLEN-1:0]  w_shamt;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_s;
   logic [XLEN-1:0]  w_imm_b;
   logic [XLEN-1:0]  w_imm_u;
   logic [XLEN-1:0]  w_imm_j;
   logic             w_bad;

   assign w_opcode   = i_instr[6:0];
   assign w_func3    = i_instr[14:12];
   assign w_func7    = i_instr[31:25];
   assign w_shift_hi = (XLEN == 64) ? {1'b0, i_instr[31:26]} : i_instr[31:25];
   assign w_shamt    = (XLEN == 64) ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);

   assign w_imm_i = XLEN'($signed(i_instr[31:20]));
   assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
   assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
   assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
   assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

   always_comb begin
      o_dec_c             = '0;
      o_dec_c.alu_control = ALU_NOP;
      o_imm_c             = '0;
      w_bad               = 1'b0;

      unique case (w_opcode)
         OPC_OP: begin
            o_dec_c.rs1       = i_instr[19:15];
            o_dec_c.rs2       = i_instr[24:20];
            o_dec_c.rd        = i_instr[11:7];
            o_dec_c.reg_write = 1'b1;
            if (w_func7 == 7'h00)                         o_dec_c.alu_control = f3_to_alu(w_func3);
            else if (w_func7 == 7'h20 && w_func3 == 3'd0) o_dec_c.alu_control = ALU_SUB;
            else if (w_func7 == 7'h20 && w_func3 == 3'd5) o_dec_c.alu_control = ALU_SRA;
            else                                          w_bad = 1'b1;
         end
         OPC_OP_IMM: begin
            o_dec_c.rs1       = i_instr[19:15];
            o_dec_c.rd        = i_instr[11:7];
            o_dec_c.reg_write = 1'b1;
            o_imm_c           = w_imm_i;
            // Shifts carry only the shift amount; the upper immediate bits select the variant.
            if (w_func3 == 3'd1) begin
               o_imm_c = w_shamt;
               if (w_shift_hi == 7'h00) o_dec_c.alu_control = ALU_SLL;
               else                     w_bad = 1'b1;
            end else if (w_func3 == 3'd5) begin
               o_imm_c = w_shamt;
               if (w_shift_hi == 7'h00)        o_dec_c.alu_control = ALU_SRL;
               else if (w_shift_hi == SRA_HI)  o_dec_c.alu_control = ALU_SRA;
               else                            w_bad = 1'b1;
            end else begin
               o_dec_c.alu_control = f3_to_alu(w_func3);
            end
         end
         OPC_LOAD: begin
            o_dec_c.rs1         = i_instr[19:15];
            o_dec_c.rd          = i_instr[11:7];
            o_dec_c.alu_control = ALU_ADD;
            o_dec_c.reg_write   = 1'b1;
            o_dec_c.mem_read    = 1'b1;
            o_imm_c             = w_imm_i;
         end
         OPC_STORE: begin
            o_dec_c.rs1         = i_instr[19:15];
            o_dec_c.rs2         = i_instr[24:20];
            o_dec_c.alu_control = ALU_ADD;
            o_dec_c.mem_write   = 1'b1;
            o_imm_c             = w_imm_s;
         end
         OPC_BRANCH: begin
            o_dec_c.rs1         = i_instr[19:15];
            o_dec_c.rs2         = i_instr[24:20];
            o_dec_c.alu_control = ALU_SUB;
            o_dec_c.branch      = 1'b1;
            o_imm_c             = w_imm_b;
         end
         OPC_LUI, OPC_AUIPC: begin
            o_dec_c.rd          = i_instr[11:7];
            o_dec_c.alu_control = ALU_ADD;
            o_dec_c.reg_write   = 1'b1;
            o_imm_c             = w_imm_u;
         end
         OPC_JAL: begin
            o_dec_c.rd          = i_instr[11:7];
            o_dec_c.alu_control = ALU_ADD;
            o_dec_c.reg_write   = 1'b1;
            o_dec_c.jump        = 1'b1;
            o_imm_c             = w_imm_j;
         end
         OPC_JALR: begin
            o_dec_c.rs1         = i_instr[19:15];
            o_dec_c.rd          = i_instr[11:7];
            o_dec_c.alu_control = ALU_ADD;
            o_dec_c.reg_write   = 1'b1;
            o_dec_c.jump        = 1'b1;
            o_imm_c             = w_imm_i;
         end
         default: w_bad = 1'b1;
      endcase

      if (w_bad) begin
         o_dec_c             = '0;
         o_dec_c.alu_control = ALU_NOP;
         o_dec_c.illegal     = 1'b1;
         o_imm_c             = '0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational decode into a 2-entry skid buffer with
// registered ready, flush, and a saturating illegal-instruction counter.
module decode_stage
   import proc_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [REG_W-1:0]   out_rs1,
   output logic [REG_W-1:0]   out_rs2,
   output logic [REG_W-1:0]   out_rd,
   output logic [ALU_W-1:0]   out_alu_control,
   output logic [XLEN-1:0]    out_imm,
   output logic [XLEN-1:0]    out_pc,
   output logic               out_reg_write,
   output logic               out_mem_read,
   output logic               out_mem_write,
   output logic               out_branch,
   output logic               out_jump,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   illegal_count
);

   dec_instr_t       w_dec;
   logic [XLEN-1:0]  w_imm;

   skid_state_e      r_state;
   skid_state_e      w_next_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_accept;
   logic             w_drain;
   logic             w_load_main;
   logic             w_load_skid;
   logic             w_skid_to_main;

   dec_instr_t       r_main;
   logic [XLEN-1:0]  r_main_imm;
   logic [XLEN-1:0]  r_main_pc;
   dec_instr_t       r_skid;
   logic [XLEN-1:0]  r_skid_imm;
   logic [XLEN-1:0]  r_skid_pc;
   logic [CNT_W-1:0] r_illegal_cnt;

   decode_core #(.XLEN(XLEN)) u_decode_core (
      .i_instr (in_instr),
      .o_dec_c (w_dec),
      .o_imm_c (w_imm)
   );

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = r_out_valid & out_ready;

   // State, valid and ready registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_in_ready  <= (w_next_state != ST_TWO);
         r_out_valid <= (w_next_state != ST_EMPTY);
      end
   end

   // Next state and buffer load controls; flush overrides everything including in_valid.
   always_comb begin
      w_next_state   = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      if (flush) begin
         w_next_state = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_next_state = ST_ONE;
                  w_load_main  = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  w_load_main = 1'b1;
               end else if (w_accept) begin
                  w_next_state = ST_TWO;
                  w_load_skid  = 1'b1;
               end else if (w_drain) begin
                  w_next_state = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_drain) begin
                  w_next_state   = ST_ONE;
                  w_skid_to_main = 1'b1;
               end
            end
            default: w_next_state = ST_EMPTY;
         endcase
      end
   end

   // Payload registers: main feeds the outputs, skid holds the overflow entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main     <= '0;
         r_main_imm <= '0;
         r_main_pc  <= '0;
         r_skid     <= '0;
         r_skid_imm <= '0;
         r_skid_pc  <= '0;
      end else begin
         if (w_load_main) begin
            r_main     <= w_dec;
            r_main_imm <= w_imm;
            r_main_pc  <= in_pc;
         end else if (w_skid_to_main) begin
            r_main     <= r_skid;
            r_main_imm <= r_skid_imm;
            r_main_pc  <= r_skid_pc;
         end
         if (w_load_skid) begin
            r_skid     <= w_dec;
            r_skid_imm <= w_imm;
            r_skid_pc  <= in_pc;
         end
      end
   end

   // Counts delivered illegal entries; saturates and survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_cnt <= '0;
      end else if (w_drain && r_main.illegal && (r_illegal_cnt != '1)) begin
         r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
   end

   assign in_ready        = r_in_ready;
   assign out_valid       = r_out_valid;
   assign out_rs1         = r_main.rs1;
   assign out_rs2         = r_main.rs2;
   assign out_rd          = r_main.rd;
   assign out_alu_control = r_main.alu_control;
   assign out_imm         = r_main_imm;
   assign out_pc          = r_main_pc;
   assign out_reg_write   = r_main.reg_write;
   assign out_mem_read    = r_main.mem_read;
   assign out_mem_write   = r_main.mem_write;
   assign out_branch      = r_main.branch;
   assign out_jump        = r_main.jump;
   assign out_illegal     = r_main.illegal;
   assign illegal_count   = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction vectors with hand-decoded
// expectations, backpressure, flush, async reset and counter saturation.
module tb_decode_stage;
   import proc_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned PW    = 26 + 2 * XLEN;

   localparam logic [4:0] F_RW = 5'b10000;
   localparam logic [4:0] F_MR = 5'b01000;
   localparam logic [4:0] F_MW = 5'b00100;
   localparam logic [4:0] F_BR = 5'b00010;
   localparam logic [4:0] F_JP = 5'b00001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_instr = '0;
   logic [XLEN-1:0]  in_pc = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [4:0]       out_rs1, out_rs2, out_rd, out_alu_control;
   logic [XLEN-1:0]  out_imm, out_pc;
   logic             out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;
   logic [CNT_W-1:0] illegal_count;

   decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_alu_control(out_alu_control), .out_imm(out_imm), .out_pc(out_pc),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
      .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     instr;
      logic [4:0]      rs1, rs2, rd, alu;
      logic [XLEN-1:0] imm, pc;
      logic [4:0]      flags;
      logic            ill;
   } exp_t;

   exp_t            q[$];
   int              checks = 0;
   int              errors = 0;
   int              exp_cnt = 0;
   logic [XLEN-1:0] pc = 32'h0000_1000;

   function automatic exp_t mk(input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input alu_op_e alu, input logic [XLEN-1:0] imm,
                               input logic [4:0] flags);
      exp_t e;
      e.instr = instr; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu;
      e.imm = imm; e.pc = '0; e.flags = flags; e.ill = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk_ill(input logic [31:0] instr);
      exp_t e;
      e = mk(instr, 5'd0, 5'd0, 5'd0, ALU_NOP, '0, 5'b0);
      e.ill = 1'b1;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Drives one instruction until accepted; the expectation is queued at acceptance.
   task automatic send(input exp_t e_in);
      exp_t e;
      bit   acc;
      int   n;
      e = e_in; e.pc = pc; acc = 1'b0; n = 0;
      in_valid = 1'b1; in_instr = e.instr; in_pc = pc;
      while (!acc && n < 50) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            q.push_back(e);
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout instr=%h: in_ready stayed 0 for %0d cycles", e.instr, n);
      end else begin
         pc = pc + XLEN'(4);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0 || out_valid) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d entries still expected, out_valid=%0b", q.size(), out_valid);
      end
   endtask

   // Monitor: pops on every delivered entry, and checks hold stability under backpressure.
   logic [PW-1:0] prev_payload;
   logic          stall_q = 1'b0;
   exp_t          m_e;

   always @(negedge clk) begin
      logic [PW-1:0] cur;
      cur = {out_rs1, out_rs2, out_rd, out_alu_control, out_imm, out_pc,
             out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q && out_valid) begin
            checks++;
            if (cur !== prev_payload) begin
               errors++;
               $display("FAIL hold_stable: payload %h changed from %h while stalled", cur, prev_payload);
            end
         end
         stall_q      = out_valid && !out_ready;
         prev_payload = cur;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: pc=%h rd=%0d illegal=%0b", out_pc, out_rd, out_illegal);
            end else begin
               logic ok;
               m_e = q.pop_front();
               ok = (out_alu_control === m_e.alu) && (out_pc === m_e.pc) && (out_illegal === m_e.ill) &&
                    ({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump} === m_e.flags);
               if (!m_e.ill)
                  ok = ok && (out_rs1 === m_e.rs1) && (out_rs2 === m_e.rs2) &&
                       (out_rd === m_e.rd) && (out_imm === m_e.imm);
               if (!ok) begin
                  errors++;
                  $display("FAIL entry instr=%h: got rs1=%0d rs2=%0d rd=%0d alu=%0d imm=%h pc=%h ctl=%b%b%b%b%b ill=%0b; expected rs1=%0d rs2=%0d rd=%0d alu=%0d imm=%h pc=%h ctl=%b ill=%0b",
                           m_e.instr, out_rs1, out_rs2, out_rd, out_alu_control, out_imm, out_pc,
                           out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal,
                           m_e.rs1, m_e.rs2, m_e.rd, m_e.alu, m_e.imm, m_e.pc, m_e.flags, m_e.ill);
               end
               if (m_e.ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
         end
      end
   end

   exp_t vec[$];

   initial begin
      vec.push_back(mk(32'h002081B3, 5'd1, 5'd2, 5'd3,  ALU_ADD,  32'h0,        F_RW));
      vec.push_back(mk(32'h407302B3, 5'd6, 5'd7, 5'd5,  ALU_SUB,  32'h0,        F_RW));
      vec.push_back(mk(32'h4030D093, 5'd1, 5'd0, 5'd1,  ALU_SRA,  32'h3,        F_RW));
      vec.push_back(mk_ill(32'h0230D093));
      vec.push_back(mk(32'hFFF00093, 5'd0, 5'd0, 5'd1,  ALU_ADD,  32'hFFFFFFFF, F_RW));
      vec.push_back(mk(32'hFE000EE3, 5'd0, 5'd0, 5'd0,  ALU_SUB,  32'hFFFFFFFC, F_BR));
      vec.push_back(mk(32'h00812183, 5'd2, 5'd0, 5'd3,  ALU_ADD,  32'h8,        F_RW | F_MR));
      vec.push_back(mk(32'hFE512C23, 5'd2, 5'd5, 5'd0,  ALU_ADD,  32'hFFFFFFF8, F_MW));
      vec.push_back(mk(32'h12345537, 5'd0, 5'd0, 5'd10, ALU_ADD,  32'h12345000, F_RW));
      vec.push_back(mk(32'h008000EF, 5'd0, 5'd0, 5'd1,  ALU_ADD,  32'h8,        F_RW | F_JP));
      vec.push_back(mk(32'h00008067, 5'd1, 5'd0, 5'd0,  ALU_ADD,  32'h0,        F_RW | F_JP));
      vec.push_back(mk(32'h00001217, 5'd0, 5'd0, 5'd4,  ALU_ADD,  32'h1000,     F_RW));
      vec.push_back(mk(32'h0020F1B3, 5'd1, 5'd2, 5'd3,  ALU_AND,  32'h0,        F_RW));
      vec.push_back(mk_ill(32'h40009093));

      // Reset values while held in reset.
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_illegal_count", 64'(illegal_count), 64'd0);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // One-cycle latency from an empty buffer.
      out_ready = 1'b1;
      send(vec[0]);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      chk("latency_out_rd", 64'(out_rd), 64'd3);
      for (int i = 1; i < vec.size(); i++) send(vec[i]);
      drain();
      chk("illegal_count_two", 64'(illegal_count), 64'd2);

      // Backpressure: two accepted, ready drops, then in-order drain.
      out_ready = 1'b0;
      send(vec[1]);
      send(vec[2]);
      in_valid = 1'b1; in_instr = vec[4].instr; in_pc = pc;
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head_rd", 64'(out_rd), 64'd5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(vec[4]);
      send(vec[6]);
      drain();

      // Flush from the full state; the instruction offered alongside must be dropped.
      out_ready = 1'b0;
      send(vec[7]);
      send(vec[8]);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = pc;
      @(negedge clk);
      q.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send(vec[9]);
      drain();
      chk("flush_keeps_count", 64'(illegal_count), 64'd2);

      // Asynchronous reset in the middle of a stalled stream.
      out_ready = 1'b0;
      send(vec[10]);
      send(vec[11]);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready), 64'd0);
      chk("async_rst_count", 64'(illegal_count), 64'd0);
      chk("async_rst_pc", 64'(out_pc), 64'd0);
      q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("async_rst_release_ready", 64'(in_ready), 64'd1);

      // Saturation of the illegal counter.
      out_ready = 1'b1;
      for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
         send(mk_ill(32'hFFFFFFFF));
         if (i == 9) begin
            drain();
            chk("count_mid", 64'(illegal_count), 64'd10);
         end
      end
      drain();
      chk("count_saturated", 64'(illegal_count), 64'd15);
      chk("count_model", 64'(illegal_count), 64'(exp_cnt));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
